div_16bit_seq: RTL
==================

Name: div_16bit_seq

Overview:
Sequential unsigned 16-bit restoring divider, one quotient bit per clock. It is the inverse-direction companion to the team's 16-bit carry-lookahead adder. Each iteration performs a trial subtraction (A + ~B + 1, borrow = NOT carry-out) and restores on borrow. It sits beside the adder in the arithmetic datapath and uses a start / out_valid / out_ready handshake.

Parameters:
WIDTH, 16, operand, quotient and remainder width. Iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
dividend  input  WIDTH  numerator; sampled on the accepted start edge
divisor  input  WIDTH  denominator; sampled on the accepted start edge
ready  output  1  high in IDLE only
out_valid  output  1  result available; held until out_ready
out_ready  input  1  consumer accepts the result
quotient  output  WIDTH  floor(dividend/divisor)
remainder  output  WIDTH  dividend mod divisor
div_by_zero  output  1  result came from divisor==0

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE
  - ready = 1, out_valid = 0
  - quotient, remainder, div_by_zero = 0
  - internal registers cleared
  - an in-flight operation is discarded with no result.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch operands; ready drops after edge k.
  - divisor!=0: go to RUN, iteration counter = 0, partial remainder = 0.
  - divisor==0: go directly to DONE with quotient = all-ones, remainder = dividend, div_by_zero = 1. out_valid is high after edge k.
- RUN, one iteration per edge (k+1 .. k+WIDTH):
  - shift {rem, dvd} left by 1.
  - trial = rem_shifted − divisor, computed at WIDTH+1 bits.
  - no borrow: rem = trial, quotient bit = 1.
  - borrow: rem unchanged (restore), quotient bit = 0.
  - after edge k+WIDTH (counter reaches WIDTH−1 and completes): go to DONE. out_valid is high after edge k+16; latency is 16 cycles for WIDTH=16.
- DONE:
  - out_valid = 1; quotient, remainder and div_by_zero are stable.
  - When out_valid & out_ready are both high at an edge: go to IDLE, out_valid = 0, ready = 1. Outputs keep their last values.
  - out_ready low: hold indefinitely, with no change to outputs.
- start while ready=0 is ignored; it is neither queued nor allowed to corrupt state.
- Start and output handshake in the same cycle: the output handshake completes in DONE, and start is accepted only from IDLE on a later edge. Minimum issue interval is therefore 18 cycles.
- Width rules:
  - the trial subtraction is WIDTH+1 bits so a shifted remainder ≥ 2^WIDTH is handled.
  - the final remainder is always < divisor and fits in WIDTH bits.
- Boundary behaviour:
  - dividend < divisor → quotient = 0, remainder = dividend.
  - divisor = 1 → quotient = dividend, remainder = 0.
  - dividend = 0 → quotient = 0, remainder = 0, full 16-cycle latency.

Decomposition:
- Shared package:
  - WIDTH default constant.
  - state enum (IDLE, RUN, DONE).
  - counter width constant, clog2(WIDTH).
  - DIV0_QUOT constant (all-ones).
- One natural sub-module, div_sub_step (combinational):
  - inputs: shifted partial remainder (WIDTH+1 bits) and divisor.
  - outputs: next remainder and quotient bit.
  - implementation: add of the inverted divisor with carry-in 1, in the same style as the team's CLA adder.
- FSM, counter and handshake stay in div_16bit_seq.

Test Plan:
1. dividend=0x1234, divisor=0x0056, out_ready=1 → out_valid 16 cycles after accept; quotient=0x0036, remainder=0x0010, div_by_zero=0.
2. 0xFFFF/0x0001 → quotient=0xFFFF, remainder=0x0000. Then 0xAAAA/0x5555 → quotient=0x0002, remainder=0x0000.
3. 0x0005/0x0007 → quotient=0x0000, remainder=0x0005. Then 0x0000/0x1234 → quotient=0, remainder=0, 16-cycle latency.
4. 0xFFFF/0x0000 → out_valid 1 cycle after accept; quotient=0xFFFF, remainder=0xFFFF, div_by_zero=1.
5. Hold out_ready=0 for 10 cycles in DONE and pulse start during RUN and DONE → outputs stable, ready=0, extra starts ignored. Then out_ready=1 → IDLE, ready=1 next cycle.
6. Assert rst_n=0 at iteration 7 of 0x1234/0x0056 → immediately ready=1, out_valid=0, outputs 0. A new op 0x0064/0x000A → quotient=0x000A, remainder=0x0000.

Source files
------------

// File: rtl/div_16bit_seq_pkg.sv
// Shared constants and types for the sequential restoring divider.
package div_16bit_seq_pkg;

    // Default operand / quotient / remainder width; also the iteration count.
    localparam int WIDTH = 16;

    // Iteration counter width (counts 0 .. WIDTH-1).
    localparam int CNT_W = $clog2(WIDTH);

    // Quotient reported for a divide by zero.
    localparam logic [WIDTH-1:0] DIV0_QUOT = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_16bit_seq_sub_step.sv
// One restoring-division step: trial subtract the divisor from the shifted
// partial remainder at W+1 bits, keep the difference when there is no borrow,
// otherwise restore the shifted remainder.
module div_sub_step #(
    parameter int W = 16
) (
    input  logic [W:0]   i_rem_sh,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_qbit
);

    logic [W:0]   w_b;
    logic [W:0]   w_g;
    logic [W:0]   w_p;
    logic [W+1:0] w_c;
    logic [W-1:0] w_diff;

    // A - B computed as A + ~B + 1 with generate/propagate carries.
    assign w_b    = ~{1'b0, i_divisor};
    assign w_g    = i_rem_sh & w_b;
    assign w_p    = i_rem_sh ^ w_b;
    assign w_c[0] = 1'b1;

    for (genvar i = 0; i <= W; i++) begin : g_carry
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    // Bit W of the difference is always zero when there is no borrow, since
    // the trial result is then below the divisor; only the low W bits matter.
    assign w_diff = w_p[W-1:0] ^ w_c[W-1:0];

    // Carry-out set means no borrow: the divisor fits, quotient bit is 1.
    assign o_qbit = w_c[W+1];
    // On a borrow the shifted remainder is below the divisor, so it fits in W bits.
    assign o_rem  = o_qbit ? w_diff : i_rem_sh[W-1:0];

endmodule

// File: rtl/div_16bit_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/ready request side and an out_valid/out_ready result side.
module div_16bit_seq
    import div_16bit_seq_pkg::*;
#(
    parameter int WIDTH = div_16bit_seq_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;      // partial remainder
    logic [WIDTH-1:0] r_dvd;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dbz;

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_rem_nxt;
    logic             w_qbit;
    logic             w_accept;
    logic             w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == LAST);
    assign w_rem_sh = {r_rem, r_dvd[WIDTH-1]};

    div_sub_step #(.W(WIDTH)) u_step (
        .i_rem_sh  (w_rem_sh),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nxt),
        .o_qbit    (w_qbit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers. Results are
    // only written when an operation finishes, so they hold through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_divisor <= '0;
            r_quot    <= '0;
            r_remo    <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_divisor <= divisor;
                        r_dvd     <= dividend;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        if (divisor == '0) begin
                            r_quot <= '1;
                            r_remo <= dividend;
                            r_dbz  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_quot <= {r_dvd[WIDTH-2:0], w_qbit};
                        r_remo <= w_rem_nxt;
                        r_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule
